load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_align.sv | 44 ++++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-type codes, FSM encoding,
// default memory depth and the request legality check.
package lsu_pkg;

    localparam int unsigned DEPTH_DEFAULT = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // Unsigned variants only exist for loads; the address must be aligned and in range.
    function automatic logic req_illegal(input logic        is_store,
                                         input logic [2:0]  funct3,
                                         input logic [31:0] addr,
                                         input int unsigned depth);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = is_store;
            F3_H:    bad = addr[0];
            F3_HU:   bad = is_store | addr[0];
            F3_W:    bad = |addr[1:0];
            default: bad = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= depth) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request and memory-port signals of the load/store unit, bundled so the
// LSU sees one slave view and its environment one master view.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        err;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [31:0] read_address;
    logic [31:0] Write_data;
    logic [31:0] Memory_dataout;

    modport slave (
        input  req_valid, is_store, funct3, addr, store_data, Memory_dataout,
        output req_ready, resp_valid, load_data, err,
        output MemoryRead, MemoryWrite, read_address, Write_data
    );

    modport master (
        output req_valid, is_store, funct3, addr, store_data, Memory_dataout,
        input  req_ready, resp_valid, load_data, err,
        input  MemoryRead, MemoryWrite, read_address, Write_data
    );

endinterface

// File: rtl/load_store_align.sv
// Little-endian lane handling: extracts and extends a loaded lane, and merges a
// sub-word store operand into the word read back from memory.
module load_store_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_d;
    logic [15:0] half_d;

    always_comb begin
        byte_d = rdata_i[7:0];
        case (offset_i)
            2'd0: byte_d = rdata_i[7:0];
            2'd1: byte_d = rdata_i[15:8];
            2'd2: byte_d = rdata_i[23:16];
            2'd3: byte_d = rdata_i[31:24];
            default: byte_d = rdata_i[7:0];
        endcase
        half_d = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B:    load_o = {{24{byte_d[7]}}, byte_d};
            F3_BU:   load_o = {24'h0, byte_d};
            F3_H:    load_o = {{16{half_d[15]}}, half_d};
            F3_HU:   load_o = {16'h0, half_d};
            default: load_o = rdata_i;
        endcase

        merge_o = rdata_i;
        case (funct3_i)
            F3_B:    merge_o[{offset_i, 3'b000} +: 8]    = wdata_i[7:0];
            F3_H:    merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half stores via read-modify-write
// on a word-wide memory that reads combinationally and writes on the clock edge.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    state_e      state_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] sd_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        err_q;
    logic [31:0] load_data_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [31:0] raddr_q;
    logic [31:0] wdata_q;
    logic [31:0] load_ext_d;
    logic [31:0] merged_d;
    logic        illegal_d;

    assign illegal_d = req_illegal(bus.is_store, bus.funct3, bus.addr, DEPTH);

    load_store_align u_align (
        .funct3_i (f3_q),
        .offset_i (off_q),
        .rdata_i  (bus.Memory_dataout),
        .wdata_i  (sd_q),
        .load_o   (load_ext_d),
        .merge_o  (merged_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            sd_q         <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            load_data_q  <= 32'h0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            raddr_q      <= 32'h0;
            wdata_q      <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        f3_q        <= bus.funct3;
                        off_q       <= bus.addr[1:0];
                        sd_q        <= bus.store_data;
                        req_ready_q <= 1'b0;
                        if (illegal_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            err_q        <= 1'b1;
                        end else begin
                            raddr_q <= {2'b00, bus.addr[31:2]};
                            if (!bus.is_store) begin
                                state_q  <= ST_LOAD;
                                mem_rd_q <= 1'b1;
                            end else if (bus.funct3 == F3_W) begin
                                state_q  <= ST_WRITE;
                                mem_wr_q <= 1'b1;
                                wdata_q  <= bus.store_data;
                            end else begin
                                state_q  <= ST_RMW_RD;
                                mem_rd_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    state_q      <= ST_RESP;
                    mem_rd_q     <= 1'b0;
                    raddr_q      <= 32'h0;
                    resp_valid_q <= 1'b1;
                    load_data_q  <= load_ext_d;
                end
                // Read strobe drops and write strobe rises on the same edge, never overlapping.
                ST_RMW_RD: begin
                    state_q  <= ST_RMW_WR;
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b1;
                    wdata_q  <= merged_d;
                end
                ST_WRITE, ST_RMW_WR: begin
                    state_q      <= ST_RESP;
                    mem_wr_q     <= 1'b0;
                    raddr_q      <= 32'h0;
                    wdata_q      <= 32'h0;
                    resp_valid_q <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    err_q        <= 1'b0;
                    load_data_q  <= 32'h0;
                    mem_rd_q     <= 1'b0;
                    mem_wr_q     <= 1'b0;
                    raddr_q      <= 32'h0;
                    wdata_q      <= 32'h0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.err          = err_q;
    assign bus.load_data    = load_data_q;
    assign bus.MemoryRead   = mem_rd_q;
    assign bus.MemoryWrite  = mem_wr_q;
    assign bus.read_address = raddr_q;
    assign bus.Write_data   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 64-word behavioural memory.
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [31:0] mem [0:63];
    int          rd_cnt, wr_cnt, both_cnt, resp_cnt, acc_cnt, cyc;
    int          acc_cyc [0:7];
    logic [31:0] last_wr_addr, last_wr_data;

    load_store_unit_if bus ();

    load_store_unit #(.DEPTH(64)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.Memory_dataout = (bus.MemoryRead && bus.read_address < 32'd64) ?
                                mem[bus.read_address[5:0]] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.MemoryRead) rd_cnt <= rd_cnt + 1;
            if (bus.MemoryWrite) begin
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= bus.read_address;
                last_wr_data <= bus.Write_data;
                if (bus.read_address < 32'd64) mem[bus.read_address[5:0]] <= bus.Write_data;
            end
            if (bus.MemoryRead && bus.MemoryWrite) both_cnt <= both_cnt + 1;
            if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
            if (bus.req_valid && bus.req_ready) begin
                if (acc_cnt < 8) acc_cyc[acc_cnt] <= cyc;
                acc_cnt <= acc_cnt + 1;
            end
        end
    end

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0; acc_cnt = 0;
        last_wr_addr = 32'hFFFF_FFFF; last_wr_data = 32'hFFFF_FFFF;
    endtask

    // Issue one request, return cycles from the accept edge to resp_valid (0 on timeout).
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, output int lat,
                          output logic [31:0] ld, output logic e);
        @(negedge clk);
        clear_counts();
        bus.req_valid = 1'b1; bus.is_store = st; bus.funct3 = f3;
        bus.addr = a; bus.store_data = sd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0; ld = 32'hX; e = 1'bX;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            if (bus.resp_valid) begin
                lat = c; ld = bus.load_data; e = bus.err;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (lat == 0) begin
            tests++; fails++;
            $display("FAIL timeout addr=%h f3=%b: no resp_valid within 6 cycles", a, f3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
        tests++;
        if ({bus.resp_valid, bus.err, bus.MemoryRead, bus.MemoryWrite} !== 4'b0 ||
            bus.load_data !== 32'h0 || bus.read_address !== 32'h0 || bus.Write_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: rv=%b err=%b rd=%b wr=%b ld=%h ra=%h wd=%h want all 0",
                     bus.resp_valid, bus.err, bus.MemoryRead, bus.MemoryWrite,
                     bus.load_data, bus.read_address, bus.Write_data);
        end
    endtask

    task automatic test_store_word();
        int lat; logic [31:0] ld; logic e;
        do_req(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, lat, ld, e);
        tests++;
        if (lat !== 2 || e !== 1'b0 || ld !== 32'h0) begin
            fails++; $display("FAIL sw_resp: lat=%0d err=%b ld=%h want 2 0 00000000", lat, e, ld);
        end
        tests++;
        if (wr_cnt !== 1 || rd_cnt !== 0) begin
            fails++; $display("FAIL sw_strobes: wr=%0d rd=%0d want 1 0", wr_cnt, rd_cnt);
        end
        tests++;
        if (last_wr_addr !== 32'd2 || last_wr_data !== 32'hDEADBEEF || mem[2] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL sw_data: ra=%h wd=%h mem2=%h want 2 DEADBEEF DEADBEEF",
                     last_wr_addr, last_wr_data, mem[2]);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [0:7];
        logic [31:0] a  [0:7];
        logic [31:0] ex [0:7];
        int lat; logic [31:0] ld; logic e;
        f3[0] = 3'b000; a[0] = 32'h09; ex[0] = 32'hFFFFFFBE;
        f3[1] = 3'b100; a[1] = 32'h09; ex[1] = 32'h000000BE;
        f3[2] = 3'b101; a[2] = 32'h0A; ex[2] = 32'h0000DEAD;
        f3[3] = 3'b010; a[3] = 32'h08; ex[3] = 32'hDEADBEEF;
        f3[4] = 3'b001; a[4] = 32'h0A; ex[4] = 32'hFFFFDEAD;
        f3[5] = 3'b000; a[5] = 32'h08; ex[5] = 32'hFFFFFFEF;
        f3[6] = 3'b100; a[6] = 32'h0B; ex[6] = 32'h000000DE;
        f3[7] = 3'b010; a[7] = 32'hFC; ex[7] = 32'h13579BDF;
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, f3[i], a[i], 32'h0, lat, ld, e);
            tests++;
            if (ld !== ex[i] || lat !== 2 || e !== 1'b0 || rd_cnt !== 1 || wr_cnt !== 0) begin
                fails++;
                $display("FAIL load_%0d f3=%b addr=%h: ld=%h lat=%0d err=%b rd=%0d wr=%0d want %h 2 0 1 0",
                         i, f3[i], a[i], ld, lat, e, rd_cnt, wr_cnt, ex[i]);
            end
        end
    endtask

    task automatic test_store_sub();
        int lat; logic [31:0] ld; logic e;
        do_req(1'b1, 3'b000, 32'h0B, 32'h00000012, lat, ld, e);
        tests++;
        if (lat !== 3 || e !== 1'b0 || ld !== 32'h0 || rd_cnt !== 1 || wr_cnt !== 1) begin
            fails++;
            $display("FAIL sb_resp: lat=%0d err=%b ld=%h rd=%0d wr=%0d want 3 0 0 1 1", lat, e, ld, rd_cnt, wr_cnt);
        end
        tests++;
        if (last_wr_data !== 32'h12ADBEEF || last_wr_addr !== 32'd2) begin
            fails++; $display("FAIL sb_data: wd=%h ra=%h want 12ADBEEF 2", last_wr_data, last_wr_addr);
        end
        do_req(1'b1, 3'b001, 32'h08, 32'hAAAA5678, lat, ld, e);
        tests++;
        if (lat !== 3 || mem[2] !== 32'h12AD5678 || last_wr_data !== 32'h12AD5678) begin
            fails++; $display("FAIL sh_data: lat=%0d mem2=%h want 3 12AD5678", lat, mem[2]);
        end
    endtask

    task automatic test_errors();
        logic        st [0:4];
        logic [2:0]  f3 [0:4];
        logic [31:0] a  [0:4];
        int lat; logic [31:0] ld; logic e;
        st[0] = 1'b0; f3[0] = 3'b010; a[0] = 32'h06;
        st[1] = 1'b0; f3[1] = 3'b010; a[1] = 32'h100;
        st[2] = 1'b1; f3[2] = 3'b001; a[2] = 32'h09;
        st[3] = 1'b1; f3[3] = 3'b100; a[3] = 32'h08;
        st[4] = 1'b0; f3[4] = 3'b011; a[4] = 32'h08;
        for (int i = 0; i < 5; i++) begin
            do_req(st[i], f3[i], a[i], 32'hFFFFFFFF, lat, ld, e);
            tests++;
            if (e !== 1'b1 || lat !== 1 || ld !== 32'h0 || rd_cnt !== 0 || wr_cnt !== 0) begin
                fails++;
                $display("FAIL err_%0d f3=%b addr=%h: err=%b lat=%0d ld=%h rd=%0d wr=%0d want 1 1 0 0 0",
                         i, f3[i], a[i], e, lat, ld, rd_cnt, wr_cnt);
            end
        end
    endtask

    task automatic test_reset_midway();
        @(negedge clk);
        clear_counts();
        bus.req_valid = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b000;
        bus.addr = 32'h0C; bus.store_data = 32'h55;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        tests++;
        if (bus.MemoryRead !== 1'b1) begin
            fails++; $display("FAIL rst_mid_rd: MemoryRead=%b want 1", bus.MemoryRead);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.req_ready !== 1'b1 || {bus.resp_valid, bus.err, bus.MemoryRead, bus.MemoryWrite} !== 4'b0 ||
            bus.load_data !== 32'h0 || bus.read_address !== 32'h0 || bus.Write_data !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_outputs: ready=%b rv=%b rd=%b wr=%b ra=%h wd=%h want 1 0 0 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.MemoryRead, bus.MemoryWrite,
                     bus.read_address, bus.Write_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL rst_mid_ready: got %b want 1", bus.req_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (wr_cnt !== 0 || resp_cnt !== 0 || mem[3] !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL rst_mid_abandon: wr=%0d resp=%0d mem3=%h want 0 0 0BADF00D", wr_cnt, resp_cnt, mem[3]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        clear_counts();
        bus.req_valid = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010;
        bus.addr = 32'h08; bus.store_data = 32'h0;
        repeat (6) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (acc_cnt !== 2) begin
            fails++; $display("FAIL b2b_accepts: got %0d want 2", acc_cnt);
        end
        tests++;
        if (acc_cnt >= 2 && acc_cyc[1] - acc_cyc[0] !== 3) begin
            fails++; $display("FAIL b2b_spacing: got %0d cycles want 3", acc_cyc[1] - acc_cyc[0]);
        end
        tests++;
        if (resp_cnt !== 2 || rd_cnt !== 2) begin
            fails++; $display("FAIL b2b_resps: resp=%0d rd=%0d want 2 2", resp_cnt, rd_cnt);
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; both_cnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[3]  = 32'h0BADF00D;
        mem[63] = 32'h13579BDF;
        for (int i = 0; i < 8; i++) acc_cyc[i] = 0;
        clear_counts();
        bus.req_valid = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b000;
        bus.addr = 32'h0; bus.store_data = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        test_store_word();
        test_loads();
        test_store_sub();
        test_errors();
        test_reset_midway();
        test_back_to_back();
        tests++;
        if (both_cnt !== 0) begin
            fails++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
